mustang_tlc: RTL and testbench
==============================

# mustang_tlc

Sequential tail-light controller for a Mustang-style vehicle: drives two 3-lamp banks (left, right) from brake and turn-signal inputs. Produces sequential "sweep" turn animations, steady brake lighting, and inverted sweeps when braking while turning. It sits between the driver-input conditioning logic and the lamp drivers; all outputs are registered.

## Interface

- No parameters.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, synchronous and active-high (one clock; reset is synchronous and active-high).
- brake  input  1  brake pedal asserted.
- turn_right  input  1  right turn signal requested.
- turn_left  input  1  left turn signal requested.
- right_tail_light_control  output  3  right lamp bank; bit0 = innermost lamp, bit2 = outermost; 1 = lamp on.
- left_tail_light_control  output  3  left lamp bank; same bit ordering.

## Operation

- Moore machine: mode register plus 2-bit phase counter (phase 0..3); outputs are a registered function of mode and phase.
- Mode is decoded each cycle from the inputs, highest priority first:
  - BRAKE_RIGHT: brake=1, turn_right=1 (turn_left ignored).
  - BRAKE_LEFT: brake=1, turn_left=1, turn_right=0.
  - BRAKE: brake=1, no turn.
  - RIGHT: brake=0, turn_right=1 (turn_right wins when both turns asserted).
  - LEFT: brake=0, turn_left=1, turn_right=0.
  - IDLE: all inputs 0.
- Output patterns per phase 0,1,2,3 (phase advances every clock, wraps 3 -> 0 while mode unchanged):
  - RIGHT: right = 001, 011, 111, 000; left = 000.
  - LEFT: left = 001, 011, 111, 000; right = 000.
  - BRAKE_RIGHT: right = 111, 110, 100, 000; left = 111.
  - BRAKE_LEFT: left = 111, 110, 100, 000; right = 111.
  - BRAKE: both = 111 (phase irrelevant).
  - IDLE: both = 000; phase held at 0.
- Mode change (decoded mode differs from registered mode): register new mode, phase forced to 0, outputs take the new mode's phase-0 pattern on that same edge.
- Unchanged mode: phase increments by 1 modulo 4.

## Timing

- rst=1 at a rising edge: mode=IDLE, phase=0, both outputs 000 after that edge; reset overrides all inputs, including mid-sequence.
- Latency: inputs sampled at edge N; corresponding output visible after edge N (one-cycle registered latency, no combinational input-to-output path).
- Turn sequence period is 4 clocks; first lit pattern (001, or 111 for brake-turn) appears on the first edge the request is sampled.
- Releasing all inputs: outputs 000 after the next edge, regardless of phase.
- Adding/removing brake during a turn restarts the sequence at phase 0 of the new mode.
- Asynchronous glitches between edges have no effect.

## Test plan

- Reset: rst=1 for 2 cycles with turn_right=1 -> both outputs 000; release rst -> right 001, 011, 111, 000, 001 on successive edges, left 000.
- Left turn: turn_left=1 only -> left 001, 011, 111, 000 repeating, right 000; drop turn_left mid-sequence -> both 000 next edge.
- Brake only: brake=1 -> both 111 every cycle; brake=0 -> both 000 next edge.
- Brake + right: brake=1, turn_right=1 -> right 111, 110, 100, 000, 111..., left steady 111; brake + left mirrored.
- Priority/restart: brake=1 with both turns -> right sweeps 111,110,100,000, left 111; during RIGHT at phase 2, assert brake -> right 111 next edge (phase 0 of BRAKE_RIGHT).

Source files
------------

// File: rtl/mustang_tlc.sv
// Sequential tail-light controller: brake/turn inputs -> two 3-lamp banks with sweep animations.
// Latency: one clock, inputs sampled on the rising edge and outputs registered on that same edge.
// Backpressure: none, the design free-runs every clock and has no handshake.
module mustang_tlc (
    input  logic       clk,
    input  logic       rst,
    input  logic       brake,
    input  logic       turn_right,
    input  logic       turn_left,
    output logic [2:0] right_tail_light_control,
    output logic [2:0] left_tail_light_control
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RIGHT       = 3'd1,
        LEFT        = 3'd2,
        BRAKE       = 3'd3,
        BRAKE_RIGHT = 3'd4,
        BRAKE_LEFT  = 3'd5
    } mode_t;

    mode_t      mode_q;
    mode_t      mode_d;
    mode_t      req_mode;
    logic [1:0] phase_q;
    logic [1:0] phase_d;
    logic [2:0] right_d;
    logic [2:0] left_d;

    // Turn sweep lights lamps from the inside out, then goes dark for one phase.
    function automatic logic [2:0] sweep_on(input logic [1:0] p);
        logic [2:0] v;
        case (p)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b011;
            2'd2:    v = 3'b111;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // Brake-turn sweep is the inverse: full bank, then lamps drop out from the inside.
    function automatic logic [2:0] sweep_off(input logic [1:0] p);
        logic [2:0] v;
        case (p)
            2'd0:    v = 3'b111;
            2'd1:    v = 3'b110;
            2'd2:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // Priority decode of the requested mode; brake dominates, right turn beats left.
    always_comb begin
        req_mode = IDLE;
        if (brake && turn_right) begin
            req_mode = BRAKE_RIGHT;
        end else if (brake && turn_left) begin
            req_mode = BRAKE_LEFT;
        end else if (brake) begin
            req_mode = BRAKE;
        end else if (turn_right) begin
            req_mode = RIGHT;
        end else if (turn_left) begin
            req_mode = LEFT;
        end
    end

    // Next phase and next lamp pattern; a mode change restarts the sweep at phase 0.
    always_comb begin
        mode_d  = req_mode;
        phase_d = 2'd0;
        right_d = 3'b000;
        left_d  = 3'b000;
        if ((req_mode == mode_q) && (req_mode != IDLE)) begin
            phase_d = phase_q + 2'd1;
        end
        case (req_mode)
            RIGHT: begin
                right_d = sweep_on(phase_d);
            end
            LEFT: begin
                left_d = sweep_on(phase_d);
            end
            BRAKE: begin
                right_d = 3'b111;
                left_d  = 3'b111;
            end
            BRAKE_RIGHT: begin
                right_d = sweep_off(phase_d);
                left_d  = 3'b111;
            end
            BRAKE_LEFT: begin
                right_d = 3'b111;
                left_d  = sweep_off(phase_d);
            end
            default: begin
                right_d = 3'b000;
                left_d  = 3'b000;
            end
        endcase
    end

    // State and output registers; reset overrides every input, even mid-sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q                   <= IDLE;
            phase_q                  <= 2'd0;
            right_tail_light_control <= 3'b000;
            left_tail_light_control  <= 3'b000;
        end else begin
            mode_q                   <= mode_d;
            phase_q                  <= phase_d;
            right_tail_light_control <= right_d;
            left_tail_light_control  <= left_d;
        end
    end

endmodule

// File: tb/tb_mustang_tlc.sv
// Self-checking bench for mustang_tlc: scoreboard of expected lamp patterns per clock.
// Latency: expectation pushed when inputs are driven, popped one edge later.
// Backpressure: none, one result per clock.
module tb_mustang_tlc;

    logic       clk;
    logic       rst;
    logic       brake;
    logic       turn_right;
    logic       turn_left;
    logic [2:0] right_tail_light_control;
    logic [2:0] left_tail_light_control;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] l;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    // Reference state: 0 idle, 1 right, 2 left, 3 brake, 4 brake+right, 5 brake+left.
    int m_mode  = 0;
    int m_phase = 0;

    logic [2:0] on_seq  [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
    logic [2:0] off_seq [4] = '{3'b111, 3'b110, 3'b100, 3'b000};

    mustang_tlc dut (
        .clk                      (clk),
        .rst                      (rst),
        .brake                    (brake),
        .turn_right               (turn_right),
        .turn_left                (turn_left),
        .right_tail_light_control (right_tail_light_control),
        .left_tail_light_control  (left_tail_light_control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One clock: glitch inputs, settle them, model the edge, then compare after it.
    task automatic step(input logic r, input logic b, input logic tr, input logic tl);
        int   req;
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst        = $urandom_range(0, 1);
        brake      = $urandom_range(0, 1);
        turn_right = $urandom_range(0, 1);
        turn_left  = $urandom_range(0, 1);
        #2;
        rst        = r;
        brake      = b;
        turn_right = tr;
        turn_left  = tl;

        if (b)       req = tr ? 4 : (tl ? 5 : 3);
        else if (tr) req = 1;
        else if (tl) req = 2;
        else         req = 0;

        if (r || req == 0) begin
            m_mode  = 0;
            m_phase = 0;
        end else if (req != m_mode) begin
            m_mode  = req;
            m_phase = 0;
        end else begin
            m_phase = (m_phase + 1) % 4;
        end

        case (m_mode)
            1:       e = '{r: on_seq[m_phase],  l: 3'b000};
            2:       e = '{r: 3'b000,           l: on_seq[m_phase]};
            3:       e = '{r: 3'b111,           l: 3'b111};
            4:       e = '{r: off_seq[m_phase], l: 3'b111};
            5:       e = '{r: 3'b111,           l: off_seq[m_phase]};
            default: e = '{r: 3'b000,           l: 3'b000};
        endcase
        sb.push_back(e);

        @(posedge clk);
        #1;
        step_no++;
        got = sb.pop_front();
        check_val($sformatf("right@%0d", step_no), {3'b000, right_tail_light_control}, {3'b000, got.r});
        check_val($sformatf("left@%0d", step_no),  {3'b000, left_tail_light_control},  {3'b000, got.l});
    endtask

    initial begin
        rst        = 1'b1;
        brake      = 1'b0;
        turn_right = 1'b0;
        turn_left  = 1'b0;

        // Reset held with a right turn requested, then the sweep starts.
        repeat (2) step(1, 0, 1, 0);
        repeat (5) step(0, 0, 1, 0);

        // Left sweep, dropped mid-sequence.
        step(1, 0, 0, 0);
        repeat (6) step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);

        // Brake alone and release.
        repeat (3) step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Brake-turn sweeps in both directions.
        repeat (6) step(0, 1, 1, 0);
        repeat (6) step(0, 1, 0, 1);
        step(0, 0, 0, 0);

        // Both turns with brake: right wins.
        repeat (5) step(0, 1, 1, 1);

        // Both turns without brake: right wins.
        repeat (3) step(0, 0, 1, 1);

        // Brake added at phase 2 of a right turn restarts at 111.
        step(0, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        repeat (2) step(0, 1, 1, 0);
        // Brake removed mid brake-turn restarts at 001.
        repeat (2) step(0, 0, 1, 0);

        // Reset in the middle of a sweep.
        repeat (2) step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);

        // Random traffic with held requests so sweeps complete.
        for (int i = 0; i < 60; i++) begin
            logic b, tr, tl, r;
            b  = $urandom_range(0, 1);
            tr = $urandom_range(0, 1);
            tl = $urandom_range(0, 1);
            r  = ($urandom_range(0, 19) == 0);
            repeat ($urandom_range(1, 6)) step(r, b, tr, tl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
